unidade_controle_drone: RTL and testbench
=========================================

Name: unidade_controle_drone

Overview:
- Moore FSM that sequences the drone game datapath.
- Runs setup (mode, lives, map select), then the move loop: wait, shift, RAM settle, collision update, evaluate.
- Drives every control strobe of the datapath. Consumes its status flags: colisao, timeout, fim_mapa, borda_movimento.
- Reports win/loss and the current state for the HEX debug display.

Parameters:
- RAM_WAIT, 1, extra cycles spent in ESPERA_RAM after a shift so the sync obstacle RAM output is valid (range 1..3).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; forces INICIAL
- iniciar  in  1  level; starts or restarts a game
- confirma  in  1  user confirm button; rising edge detected internally
- borda_movimento  in  1  pulse from datapath: a direction edge occurred
- timeout  in  1  move timer expired, for the selected mode
- colisao  in  1  collision count equals lives
- fim_mapa  in  1  horizontal position = 15
- zeraPosicoes, resetaVidas, zeraT, contaT, desloca, escolhe_modo, escolhe_vida, escolhe_mapa, checa_colisao, atualiza  out  1 each  datapath strobes
- ganhou  out  1  win indicator
- perdeu  out  1  loss indicator
- db_estado  out  4  current state encoding

Behaviour:
- Reset (async): state=INICIAL, confirma edge register=0, RAM_WAIT counter=0. All outputs 0; db_estado=4'h0.
- Outputs are decoded from the state only (Moore), so they change one clock after each transition.
- confirma_pulso = confirma & ~confirma_q, where confirma_q is a registered copy. At most one advance per press.
- States, encoding, asserted outputs, transitions:
  - 0 INICIAL: none. If iniciar, go to 1.
  - 1 PREPARA: zeraPosicoes, resetaVidas, zeraT. Always go to 2.
  - 2 MODO: escolhe_modo. On confirma_pulso, go to 3.
  - 3 VIDAS: escolhe_vida. On confirma_pulso, go to 4.
  - 4 MAPA: escolhe_mapa. On confirma_pulso, go to 5.
  - 5 INICIA_JOGADA: zeraT. Always go to 6.
  - 6 ESPERA_JOGADA: contaT. If borda_movimento, go to 7. Else if timeout, go to D. Else stay.
  - 7 DESLOCA: desloca. Go to 8.
  - 8 ESPERA_RAM: none. Stays RAM_WAIT cycles (counter cleared on entry), then goes to 9.
  - 9 ATUALIZA: atualiza. Go to A.
  - A CHECA: checa_colisao, atualiza. Go to B.
  - B AVALIA: none. If colisao, go to D. Else if fim_mapa, go to C. Else go to 5.
  - C GANHOU: ganhou. If iniciar, go to 1.
  - D PERDEU: perdeu. If iniciar, go to 1.
  - Unused encodings E, F: go to INICIAL next cycle.
- Simultaneous events:
  - In ESPERA_JOGADA, borda_movimento beats timeout.
  - In AVALIA, colisao beats fim_mapa (a collision on the last column loses).
- iniciar held high during setup or play has no effect. It acts only in INICIAL, GANHOU and PERDEU.
- confirma edges outside states 2–4 are ignored. The edge register still updates every cycle.
- Reset asserted mid-game returns to INICIAL immediately. All strobes drop asynchronously.
- Latency, borda_movimento to the AVALIA decision: 4 + RAM_WAIT clocks.

Optional Feature:
- Macro: PAUSA_EN.
- When defined:
  - Adds input pausa (1 bit) and state E PAUSADO, with no outputs asserted (contaT=0, so the timer freezes).
  - ESPERA_JOGADA goes to PAUSADO when pausa=1. This has priority over borda_movimento and timeout.
  - PAUSADO returns to ESPERA_JOGADA when pausa=0, without asserting zeraT.
- When undefined:
  - No pausa port.
  - Encoding E is illegal and recovers to INICIAL.

Test Plan:
- Reset mid-play: reset pulse while in ESPERA_JOGADA -> db_estado=0 and contaT=0 in the same cycle, before the next clock edge.
- Setup flow: iniciar=1, then 3 confirma presses each held 5 cycles -> db_estado sequence 0,1,2,3,4,5,6, with exactly one step per press.
- Clean move: in 6, pulse borda_movimento with colisao=0 and fim_mapa=0 -> desloca high 1 cycle, atualiza in 9 and A, checa_colisao in A, back to 5 after 6 clocks (RAM_WAIT=1).
- Collision at last column: colisao=1 and fim_mapa=1 in AVALIA -> state D, perdeu=1, ganhou=0. Then iniciar -> state 1.
- Timeout race: borda_movimento and timeout high in the same cycle in 6 -> state 7 (not D). timeout alone -> state D.
- PAUSA_EN build: pausa=1 in 6 -> state E with contaT=0. pausa=0 -> state 6 with contaT=1 and no zeraT pulse.

Source files
------------

// File: rtl/unidade_controle_drone.sv
// unidade_controle_drone: Moore FSM sequencing setup and the move loop of the drone game datapath.
// Optional PAUSA_EN adds the pausa input and the PAUSADO state (encoding E).
module unidade_controle_drone #(
    parameter int RAM_WAIT = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       confirma,
    input  logic       borda_movimento,
    input  logic       timeout,
    input  logic       colisao,
    input  logic       fim_mapa,
`ifdef PAUSA_EN
    input  logic       pausa,
`endif
    output logic       zeraPosicoes,
    output logic       resetaVidas,
    output logic       zeraT,
    output logic       contaT,
    output logic       desloca,
    output logic       escolhe_modo,
    output logic       escolhe_vida,
    output logic       escolhe_mapa,
    output logic       checa_colisao,
    output logic       atualiza,
    output logic       ganhou,
    output logic       perdeu,
    output logic [3:0] db_estado
);
    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARA       = 4'h1,
        MODO          = 4'h2,
        VIDAS         = 4'h3,
        MAPA          = 4'h4,
        INICIA_JOGADA = 4'h5,
        ESPERA_JOGADA = 4'h6,
        DESLOCA       = 4'h7,
        ESPERA_RAM    = 4'h8,
        ATUALIZA      = 4'h9,
        CHECA         = 4'hA,
        AVALIA        = 4'hB,
        GANHOU        = 4'hC,
`ifdef PAUSA_EN
        PERDEU        = 4'hD,
        PAUSADO       = 4'hE
`else
        PERDEU        = 4'hD
`endif
    } estado_t;

    localparam logic [1:0] ULTIMO = 2'(RAM_WAIT - 1);

    estado_t    estado, prox;
    logic       confirma_q;
    logic [1:0] cnt;
    logic       confirma_pulso;

    assign confirma_pulso = confirma & ~confirma_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= INICIAL;
            confirma_q <= 1'b0;
            cnt        <= 2'd0;
        end else begin
            estado     <= prox;
            confirma_q <= confirma;
            cnt        <= (estado == ESPERA_RAM) ? cnt + 2'd1 : 2'd0;
        end
    end

    always_comb begin
        prox = INICIAL;
        case (estado)
            INICIAL:       prox = iniciar ? PREPARA : INICIAL;
            PREPARA:       prox = MODO;
            MODO:          prox = confirma_pulso ? VIDAS : MODO;
            VIDAS:         prox = confirma_pulso ? MAPA : VIDAS;
            MAPA:          prox = confirma_pulso ? INICIA_JOGADA : MAPA;
            INICIA_JOGADA: prox = ESPERA_JOGADA;
`ifdef PAUSA_EN
            ESPERA_JOGADA: prox = pausa ? PAUSADO : borda_movimento ? DESLOCA : timeout ? PERDEU : ESPERA_JOGADA;
            PAUSADO:       prox = pausa ? PAUSADO : ESPERA_JOGADA;
`else
            ESPERA_JOGADA: prox = borda_movimento ? DESLOCA : timeout ? PERDEU : ESPERA_JOGADA;
`endif
            DESLOCA:       prox = ESPERA_RAM;
            // cnt is zero on entry, so ESPERA_RAM lasts exactly RAM_WAIT cycles
            ESPERA_RAM:    prox = (cnt == ULTIMO) ? ATUALIZA : ESPERA_RAM;
            ATUALIZA:      prox = CHECA;
            CHECA:         prox = AVALIA;
            AVALIA:        prox = colisao ? PERDEU : fim_mapa ? GANHOU : INICIA_JOGADA;
            GANHOU:        prox = iniciar ? PREPARA : GANHOU;
            PERDEU:        prox = iniciar ? PREPARA : PERDEU;
            default:       prox = INICIAL;
        endcase
        zeraPosicoes  = estado == PREPARA;
        resetaVidas   = estado == PREPARA;
        zeraT         = estado == PREPARA || estado == INICIA_JOGADA;
        contaT        = estado == ESPERA_JOGADA;
        desloca       = estado == DESLOCA;
        escolhe_modo  = estado == MODO;
        escolhe_vida  = estado == VIDAS;
        escolhe_mapa  = estado == MAPA;
        checa_colisao = estado == CHECA;
        atualiza      = estado == ATUALIZA || estado == CHECA;
        ganhou        = estado == GANHOU;
        perdeu        = estado == PERDEU;
    end

    assign db_estado = estado;
endmodule

// File: tb/tb_unidade_controle_drone.sv
// tb_unidade_controle_drone: directed-vector bench for the drone control FSM (RAM_WAIT=1).
module tb_unidade_controle_drone;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic iniciar = 1'b0, confirma = 1'b0, borda_movimento = 1'b0;
    logic timeout = 1'b0, colisao = 1'b0, fim_mapa = 1'b0;
`ifdef PAUSA_EN
    logic pausa = 1'b0;
`endif
    logic zeraPosicoes, resetaVidas, zeraT, contaT, desloca, escolhe_modo;
    logic escolhe_vida, escolhe_mapa, checa_colisao, atualiza, ganhou, perdeu;
    logic [3:0] db_estado;
    logic [11:0] outs;
    int vectors = 0;
    int miscompares = 0;

    unidade_controle_drone #(.RAM_WAIT(1)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .confirma(confirma),
        .borda_movimento(borda_movimento), .timeout(timeout), .colisao(colisao), .fim_mapa(fim_mapa),
`ifdef PAUSA_EN
        .pausa(pausa),
`endif
        .zeraPosicoes(zeraPosicoes), .resetaVidas(resetaVidas), .zeraT(zeraT), .contaT(contaT),
        .desloca(desloca), .escolhe_modo(escolhe_modo), .escolhe_vida(escolhe_vida),
        .escolhe_mapa(escolhe_mapa), .checa_colisao(checa_colisao), .atualiza(atualiza),
        .ganhou(ganhou), .perdeu(perdeu), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // bit order: zp rv zT cT des modo vida mapa cc at g p
    assign outs = {zeraPosicoes, resetaVidas, zeraT, contaT, desloca, escolhe_modo,
                   escolhe_vida, escolhe_mapa, checa_colisao, atualiza, ganhou, perdeu};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] st, input logic [11:0] o);
        vectors++;
        assert (db_estado === st && outs === o) else begin
            miscompares++;
            $error("FAIL %s: got estado=%h outs=%h expected estado=%h outs=%h", tag, db_estado, outs, st, o);
        end
    endtask

    task automatic press();
        confirma = 1'b1;
        tick();
        confirma = 1'b0;
        tick();
    endtask

    task automatic setup_to_play();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        press();
        press();
        press();
    endtask

    initial begin
        tick();
        chk("reset", 4'h0, 12'h000);
        reset = 1'b0;
        tick();
        chk("idle", 4'h0, 12'h000);
        iniciar = 1'b1;
        tick();
        chk("prepara", 4'h1, 12'hE00);
        tick();
        chk("modo", 4'h2, 12'h040);
        iniciar = 1'b0;
        confirma = 1'b1;
        tick();
        chk("press1", 4'h3, 12'h020);
        repeat (4) tick();
        chk("press1_held", 4'h3, 12'h020);
        confirma = 1'b0;
        tick();
        confirma = 1'b1;
        tick();
        chk("press2", 4'h4, 12'h010);
        repeat (4) tick();
        chk("press2_held", 4'h4, 12'h010);
        confirma = 1'b0;
        tick();
        confirma = 1'b1;
        tick();
        chk("inicia_jogada", 4'h5, 12'h200);
        tick();
        chk("espera_jogada", 4'h6, 12'h100);
        repeat (3) tick();
        chk("press3_held", 4'h6, 12'h100);
        confirma = 1'b0;
        tick();
        // clean move
        borda_movimento = 1'b1;
        tick();
        chk("desloca", 4'h7, 12'h080);
        borda_movimento = 1'b0;
        tick();
        chk("espera_ram", 4'h8, 12'h000);
        tick();
        chk("atualiza", 4'h9, 12'h004);
        tick();
        chk("checa", 4'hA, 12'h00C);
        tick();
        chk("avalia", 4'hB, 12'h000);
        tick();
        chk("back_to_5", 4'h5, 12'h200);
        tick();
        chk("back_to_6", 4'h6, 12'h100);
        // borda beats timeout, then win on last column
        borda_movimento = 1'b1;
        timeout = 1'b1;
        tick();
        chk("race", 4'h7, 12'h080);
        borda_movimento = 1'b0;
        timeout = 1'b0;
        fim_mapa = 1'b1;
        repeat (4) tick();
        chk("avalia_win", 4'hB, 12'h000);
        tick();
        chk("ganhou", 4'hC, 12'h002);
        fim_mapa = 1'b0;
        tick();
        chk("ganhou_hold", 4'hC, 12'h002);
        setup_to_play();
        chk("replay", 4'h6, 12'h100);
        // timeout alone loses
        timeout = 1'b1;
        tick();
        chk("timeout", 4'hD, 12'h001);
        timeout = 1'b0;
        iniciar = 1'b1;
        tick();
        chk("restart_from_d", 4'h1, 12'hE00);
        iniciar = 1'b0;
        tick();
        press();
        press();
        press();
        // collision on last column loses
        borda_movimento = 1'b1;
        colisao = 1'b1;
        fim_mapa = 1'b1;
        tick();
        borda_movimento = 1'b0;
        repeat (4) tick();
        chk("avalia_col", 4'hB, 12'h000);
        tick();
        chk("col_last", 4'hD, 12'h001);
        colisao = 1'b0;
        fim_mapa = 1'b0;
        setup_to_play();
        // iniciar and confirma ignored during play
        iniciar = 1'b1;
        tick();
        chk("iniciar_ign", 4'h6, 12'h100);
        iniciar = 1'b0;
        press();
        chk("confirma_ign", 4'h6, 12'h100);
`ifdef PAUSA_EN
        pausa = 1'b1;
        borda_movimento = 1'b1;
        tick();
        chk("pausado", 4'hE, 12'h000);
        borda_movimento = 1'b0;
        tick();
        chk("pausado_hold", 4'hE, 12'h000);
        pausa = 1'b0;
        tick();
        chk("retoma", 4'h6, 12'h100);
`endif
        // async reset mid-play, checked before the next edge
        reset = 1'b1;
        #1;
        chk("async_reset", 4'h0, 12'h000);
        tick();
        reset = 1'b0;
        tick();
        chk("after_reset", 4'h0, 12'h000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
